// File: rtl/imem_loader.sv
// imem_loader: byte-serial loader that packs a stream into instruction-buffer lines.
// Define IMEM_LOADER_CHECKSUM_EN to add a trailing checksum byte and load_error.
module imem_loader #(
  parameter int d_width       = 8,
  parameter int i_adr_width   = 10,
  parameter int i_width       = 20,
  parameter int i_buffer_size = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 load_start,
  input  logic [i_adr_width-1:0]               load_base,
  input  logic [i_adr_width-1:0]               load_count,
  input  logic [d_width-1:0]                   byte_in,
  input  logic                                 byte_valid,
  output logic                                 byte_ready,
  output logic [i_adr_width-1:0]               imem_write_adr,
  output logic                                 imem_write,
  output logic [i_buffer_size*i_width-1:0]     imem_in,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 core_reset,
  output logic                                 load_error
);

  localparam int LW = i_buffer_size * i_width;
  localparam int NB = (LW + d_width - 1) / d_width;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW = NB * d_width;
  localparam logic [IW-1:0] LAST = IW'(NB - 1);
  localparam logic [i_adr_width-1:0] ONE = i_adr_width'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [i_adr_width-1:0] adr_q, adr_d;
  logic [i_adr_width-1:0] rem_q, rem_d;
  logic [i_adr_width-1:0] wadr_q, wadr_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [AW-1:0]          asm_q, asm_d;
  logic [LW-1:0]          line_q, line_d;
  logic                   ready_q, ready_d;
  logic                   write_q, write_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   crst_q, crst_d;
  logic                   xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [d_width-1:0]     sum_q, sum_d;
  logic                   err_q, err_d;
`endif

  assign xfer = byte_valid & ready_q;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    wadr_d  = wadr_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    line_d  = line_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          adr_d = load_base;
          rem_d = load_count;
          idx_d = '0;
          asm_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d = '0;
          err_d = 1'b0;
`endif
          state_d = (load_count == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (xfer) begin
          asm_d[int'(idx_q) * d_width +: d_width] = byte_in;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d = sum_q + byte_in;
`endif
          if (idx_q == LAST) begin
            idx_d   = '0;
            line_d  = asm_d[LW-1:0];
            wadr_d  = adr_q;
            state_d = S_WRITE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_WRITE: begin
        adr_d = adr_q + ONE;
        rem_d = rem_q - ONE;
        if (rem_q != ONE) begin
          state_d = S_COLLECT;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) begin
          err_d   = (byte_in != sum_q);
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // outputs are registered from the next state so they line up with it
    ready_d = (state_d == S_COLLECT) || (state_d == S_CHECK);
    write_d = (state_d == S_WRITE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
    crst_d  = busy_d | err_d;
`else
    crst_d  = busy_d;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      wadr_q  <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      line_q  <= '0;
      ready_q <= 1'b0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      crst_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      wadr_q  <= wadr_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      line_q  <= line_d;
      ready_q <= ready_d;
      write_q <= write_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      crst_q  <= crst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  assign byte_ready     = ready_q;
  assign imem_write     = write_q;
  assign imem_write_adr = wadr_q;
  assign imem_in        = line_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign core_reset     = crst_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign load_error     = err_q;
`else
  assign load_error     = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench with a line-packing model and per-cycle compare.
// Build with IMEM_LOADER_CHECKSUM_EN defined to exercise the checksum path.
module tb_imem_loader;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int LW = 40;
  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_start = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic [AW-1:0] load_count = '0;
  logic [DW-1:0] byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic [AW-1:0] imem_write_adr;
  logic          imem_write;
  logic [LW-1:0] imem_in;
  logic          busy;
  logic          done;
  logic          core_reset;
  logic          load_error;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk),
    .reset(reset),
    .load_start(load_start),
    .load_base(load_base),
    .load_count(load_count),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .imem_write_adr(imem_write_adr),
    .imem_write(imem_write),
    .imem_in(imem_in),
    .busy(busy),
    .done(done),
    .core_reset(core_reset),
    .load_error(load_error)
  );

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] q_adr[$];
  logic [LW-1:0] q_line[$];
  logic [DW-1:0] pay[$];
  logic [AW-1:0] last_adr = '0;
  logic [LW-1:0] last_line = '0;
  logic [AW-1:0] ea;
  logic [LW-1:0] el;
  int exp_done = 0;
  int done_seen = 0;
  int busy_cycles = 0;
  logic exp_err = 1'b0;
  logic bad_pending = 1'b0;
  logic prev_busy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected writes: line i goes to (base+i) mod 2^AW, bytes little-endian
  task automatic expect_lines(input logic [AW-1:0] base, input int n);
    logic [LW-1:0] line;
    for (int i = 0; i < n; i++) begin
      line = '0;
      for (int k = 0; k < NB; k++) line[k*DW +: DW] = pay[i*NB + k];
      q_adr.push_back(AW'((int'(base) + i) % 1024));
      q_line.push_back(line);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      last_adr  = '0;
      last_line = '0;
      exp_err   = 1'b0;
      bad_pending = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (imem_write) begin
        if (q_adr.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          ea = q_adr.pop_front();
          el = q_line.pop_front();
          chk("write_adr", imem_write_adr, ea);
          chk("write_line", imem_in, el);
          last_adr  = ea;
          last_line = el;
        end
      end else begin
        chk("hold_adr", imem_write_adr, last_adr);
        chk("hold_line", imem_in, last_line);
      end
      chk("ready_during_write", byte_ready & imem_write, 0);
      if (busy && !prev_busy) exp_err = 1'b0;
      if (done) begin
        done_seen++;
        chk("done_busy", busy, 1);
        if (bad_pending) begin
          exp_err = 1'b1;
          bad_pending = 1'b0;
        end
      end
      chk("load_error", load_error, exp_err);
      chk("core_reset", core_reset, busy | exp_err);
      if (busy) busy_cycles++;
      prev_busy = busy;
    end
  end

  task automatic start(input logic [AW-1:0] base, input logic [AW-1:0] cnt);
    load_start = 1'b1;
    load_base  = base;
    load_count = cnt;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [DW-1:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      byte_in = DW'($urandom);
      @(negedge clk);
    end
    byte_in = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", 1, 0);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic send_sum(input int first, input int n);
    logic [DW-1:0] s = '0;
    for (int i = 0; i < n; i++) s = s + pay[first + i];
    send_byte(s, 0);
  endtask

  task automatic do_load(input logic [AW-1:0] base, input int cnt,
                         input int gapmax);
    expect_lines(base, cnt);
    exp_done++;
    start(base, AW'(cnt));
    @(negedge clk);
    for (int i = 0; i < cnt * NB; i++)
      send_byte(pay[i], gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (cnt != 0) send_sum(0, cnt * NB);
`endif
    wait_idle();
  endtask

  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", byte_ready, 0);
    chk("rst_write", imem_write, 0);
    chk("rst_adr", imem_write_adr, 0);
    chk("rst_in", imem_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_core_reset", core_reset, 0);
    chk("rst_load_error", load_error, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // single line, back-to-back after one idle COLLECT cycle
    pay = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    expect_lines(10'h010, 1);
    chk("model_pack", q_line[0], 40'h5544332211);
    exp_done++;
    busy_cycles = 0;
    start(10'h010, 10'd1);
    chk("t1_ready", byte_ready, 1);
    @(negedge clk);
    for (int i = 0; i < NB; i++) send_byte(pay[i], 0);
    chk("t1_write", imem_write, 1);
    chk("t1_adr", imem_write_adr, 10'h010);
    chk("t1_line", imem_in, 40'h5544332211);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_sum(0, NB);
    wait_idle();
    chk("t1_busy_cycles", busy_cycles, 9);
`else
    @(negedge clk);
    chk("t1_done", done, 1);
    wait_idle();
    chk("t1_busy_cycles", busy_cycles, 8);
`endif

    // address wrap
    pay = {};
    for (int i = 0; i < 2 * NB; i++) pay.push_back(DW'(8'hA0 + i));
    do_load(10'h3FF, 2, 0);
    chk("t2_wrap_adr", imem_write_adr, 10'h000);
    chk("t2_wrap_line", imem_in, 40'hA9A8A7A6A5);

    // random gaps, valid held through WRITE
    pay = {};
    for (int i = 0; i < 4 * NB; i++) pay.push_back(DW'($urandom));
    do_load(10'h080, 4, 3);
    chk("t3_last_adr", imem_write_adr, 10'h083);

    // zero count
    exp_done++;
    start(10'h055, 10'd0);
    chk("t4_done", done, 1);
    chk("t4_nowrite", imem_write, 0);
    @(negedge clk);
    chk("t4_idle", busy, 0);

    // start mid-load is ignored
    pay = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    expect_lines(10'h020, 1);
    exp_done++;
    start(10'h020, 10'd1);
    @(negedge clk);
    send_byte(pay[0], 0);
    send_byte(pay[1], 0);
    start(10'h300, 10'd7);
    for (int i = 2; i < NB; i++) send_byte(pay[i], 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_sum(0, NB);
`endif
    wait_idle();
    chk("t4_ignored_adr", imem_write_adr, 10'h020);

    // reset after 3 bytes of line 2
    pay = {};
    for (int i = 0; i < 3 * NB; i++) pay.push_back(DW'(8'h30 + i));
    expect_lines(10'h100, 1);
    start(10'h100, 10'd3);
    @(negedge clk);
    for (int i = 0; i < NB + 3; i++) send_byte(pay[i], 0);
    reset = 1'b1;
    #1;
    chk("t5_ready", byte_ready, 0);
    chk("t5_write", imem_write, 0);
    chk("t5_adr", imem_write_adr, 0);
    chk("t5_in", imem_in, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_core_reset", core_reset, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pay = {};
    for (int i = 0; i < 2 * NB; i++) pay.push_back(DW'($urandom));
    do_load(10'h1F0, 2, 1);
    chk("t5_reload_adr", imem_write_adr, 10'h1F1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pay = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    expect_lines(10'h040, 1);
    exp_done++;
    start(10'h040, 10'd1);
    @(negedge clk);
    for (int i = 0; i < NB; i++) send_byte(pay[i], 0);
    send_byte(8'h0F, 0);
    wait_idle();
    chk("t6_good_err", load_error, 0);
    chk("t6_good_crst", core_reset, 0);

    expect_lines(10'h041, 1);
    exp_done++;
    start(10'h041, 10'd1);
    @(negedge clk);
    for (int i = 0; i < NB; i++) send_byte(pay[i], 0);
    bad_pending = 1'b1;
    send_byte(8'h10, 0);
    wait_idle();
    repeat (4) @(negedge clk);
    chk("t6_bad_err", load_error, 1);
    chk("t6_bad_crst", core_reset, 1);
    chk("t6_bad_idle", busy, 0);

    do_load(10'h042, 1, 0);
    chk("t6_cleared_err", load_error, 0);
    chk("t6_cleared_crst", core_reset, 0);
`endif

    chk("done_count", done_seen, exp_done);
    chk("writes_drained", q_adr.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-serial program loader that drives the write side of the instruction buffer (`imem_write_adr`, `imem_write`, `imem_in`). It accepts a stream of `d_width`-bit bytes over a valid/ready handshake and packs them into `i_buffer_size*i_width`-bit buffer lines. Each completed line is written to consecutive addresses. The PAT core is held in reset while a load is in progress.

## Interface
- `d_width`, 8: byte width of the input stream.
- `i_adr_width`, 10: instruction-buffer line address width.
- `i_width`, 20: instruction width.
- `i_buffer_size`, 2: instructions per buffer line; line width `LW = i_buffer_size*i_width` (40).
- Derived `NB = ceil(LW/d_width)` (5): bytes per line.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load_start`  in  1  request a load; sampled only in IDLE.
- `load_base`  in  `i_adr_width`  first line address; latched with `load_start`.
- `load_count`  in  `i_adr_width`  number of lines; latched with `load_start`.
- `byte_in`  in  `d_width`  stream data.
- `byte_valid`  in  1  stream data valid.
- `byte_ready`  out  1  loader can accept a byte.
- `imem_write_adr`  out  `i_adr_width`  line write address.
- `imem_write`  out  1  one-cycle line write strobe.
- `imem_in`  out  `LW`  packed line.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse at end of load.
- `core_reset`  out  1  hold the PAT core in reset.
- `load_error`  out  1  checksum mismatch (only with `IMEM_LOADER_CHECKSUM_EN`).

## Operation
- States: IDLE, COLLECT, WRITE, CHECK (macro only), DONE.
- IDLE:
  - `byte_ready=0`.
  - On `load_start`, latch `load_base` into the address register and `load_count` into `remaining`. Clear the byte index, assembly register and checksum.
  - Go to COLLECT, or to DONE if `load_count==0`.
- COLLECT:
  - `byte_ready=1`. A byte transfers when `byte_valid & byte_ready`.
  - Byte k of a line (k=0..NB-1) goes into bits `[k*d_width +: d_width]`, little-endian. Bits above LW-1 in the last byte are discarded.
  - When the byte with k=NB-1 transfers, go to WRITE.
- WRITE:
  - `imem_write=1` for exactly one cycle, with `imem_in` = assembled line and `imem_write_adr` = current address. `byte_ready=0`.
  - On leaving WRITE: address += 1, wrapping modulo `2^i_adr_width`; `remaining` -= 1.
  - Next state: COLLECT if `remaining != 1`; otherwise CHECK (macro) or DONE.
- DONE: `done=1` for one cycle, then IDLE.
- `busy=1` in every state except IDLE. `core_reset` = `busy`, except when `load_error` is set, which keeps it high (see Configuration).
- `load_start` outside IDLE is ignored. `byte_valid` in IDLE or WRITE is not consumed.
- Outputs `imem_write_adr` and `imem_in` hold their last values outside WRITE.
- Asynchronous `reset` mid-load aborts immediately. Partially assembled bytes are lost, and lines already written are not undone.

## Timing
- Reset values: `byte_ready=0`, `imem_write=0`, `imem_write_adr=0`, `imem_in=0`, `busy=0`, `done=0`, `core_reset=0`, `load_error=0`.
- `load_start` at edge N puts the block in COLLECT at N+1, so `byte_ready=1` from that cycle on.
- `imem_write` is asserted in the cycle after the final byte of a line is accepted.
- Maximum throughput: NB+1 cycles per line (6 at defaults).
- `done` is asserted in the cycle after the last WRITE (or after CHECK). `busy` and `core_reset` drop in the cycle after `done`.
- The handshake is registered-state only: `byte_ready` does not depend combinationally on `byte_valid`.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - After the last line, the loader enters CHECK with `byte_ready=1` and accepts one extra byte.
  - This byte must equal the sum, modulo `2^d_width`, of all payload bytes.
  - On mismatch, `load_error` sets; it is sticky and is cleared only by the next accepted `load_start` or by `reset`.
  - While `load_error=1`, `core_reset` stays 1 even in IDLE.
  - `done` still pulses on both match and mismatch.
- Macro undefined: no CHECK state, no checksum byte is consumed, and `load_error` is tied to 0.

## Test plan
- Single line, macro off: `load_base=0x010`, `load_count=1`, bytes 0x11,0x22,0x33,0x44,0x55 back-to-back -> one `imem_write` at adr 0x010 with `imem_in=0x5544332211`, `done` 1 cycle later, `busy` high for 8 cycles total.
- Address wrap: `load_base=0x3FF`, `load_count=2` -> writes at 0x3FF then 0x000.
- Backpressure and gaps: `byte_valid` toggled randomly, plus `byte_valid` held high during WRITE -> no byte lost or duplicated, and `imem_in` matches the expected packing for 4 lines.
- Zero count and ignored start: `load_count=0` -> `done` the cycle after start with no write. A second `load_start` mid-load -> ignored.
- Reset mid-load: assert `reset` after 3 bytes of line 2 -> all outputs return to 0 immediately, and a new load then completes correctly.
- Macro on: 1 line of bytes 0x01..0x05 then checksum 0x0F -> `load_error=0`. Checksum 0x10 -> `load_error=1` and `core_reset` held high in IDLE until the next `load_start`.
